// File: rtl/motor_pwm_driver.sv
// Two-wheel motor PWM driver: ramped duty per wheel, boundary-aligned PWM update,
// plus blinking indicator lamps and a steady tail light.
//
// state | meaning
// OFF   | engine disabled, duties and PWM forced to 0
// RUN   | engine enabled, duties ramp toward speed/direction targets
module motor_pwm_driver #(
   parameter int PWM_BITS  = 8,
   parameter int RAMP_DIV  = 16,
   parameter int STEP      = 4,
   parameter int BLINK_DIV = 1 << 20
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                E,
   input  logic [2:0]          M1,
   input  logic [1:0]          M2,
   input  logic                RH,
   input  logic                LH,
   input  logic                TL,
   output logic                pwm_l,
   output logic                pwm_r,
   output logic [PWM_BITS-1:0] duty_l,
   output logic [PWM_BITS-1:0] duty_r,
   output logic                ramping,
   output logic                rh_lamp,
   output logic                lh_lamp,
   output logic                tl_lamp
);

   localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   typedef enum logic {ST_OFF = 1'b0, ST_RUN = 1'b1} state_t;

   state_t state_q, state_d;
   logic   run_en, run_now;

   logic [RW-1:0]       div_q, div_d;
   logic [PWM_BITS-1:0] cnt_q, cnt_d;
   logic [PWM_BITS-1:0] duty_l_q, duty_l_d, duty_r_q, duty_r_d;
   logic [PWM_BITS-1:0] app_l_q, app_l_d, app_r_q, app_r_d;
   logic                pwm_l_q, pwm_l_d, pwm_r_q, pwm_r_d;
   logic [BW-1:0]       blink_q, blink_d;
   logic                phase_q, phase_d;
   logic                rh_q, rh_d, lh_q, lh_d, tl_q, tl_d;

   logic [PWM_BITS-1:0] base, tgt_l, tgt_r;
   logic                tick;

   // Move one step toward the target, landing exactly on it when close enough.
   function automatic logic [PWM_BITS-1:0] ramp_step(input logic [PWM_BITS-1:0] cur,
                                                     input logic [PWM_BITS-1:0] tgt);
      logic [PWM_BITS:0] diff;
      if (tgt >= cur) begin
         diff = {1'b0, tgt} - {1'b0, cur};
         ramp_step = (diff <= (PWM_BITS+1)'(STEP)) ? tgt : cur + PWM_BITS'(STEP);
      end else begin
         diff = {1'b0, cur} - {1'b0, tgt};
         ramp_step = (diff <= (PWM_BITS+1)'(STEP)) ? tgt : cur - PWM_BITS'(STEP);
      end
   endfunction

   always_ff @(posedge clk) begin
      if (clr) state_q <= ST_OFF;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_OFF:  if (E)  state_d = ST_RUN;
         ST_RUN:  if (!E) state_d = ST_OFF;
         default: state_d = ST_OFF;
      endcase
   end

   // run_en looks at the next state so that dropping E clears outputs on the very next edge.
   always_comb begin
      run_en  = (state_d == ST_RUN);
      run_now = (state_q == ST_RUN);
   end

   always_comb begin
      case (M1)
         3'd1:    base = PWM_BITS'(64);
         3'd2:    base = PWM_BITS'(128);
         3'd3:    base = PWM_BITS'(192);
         default: base = '0;
      endcase
      case (M2)
         2'd1:    begin tgt_l = base;      tgt_r = base >> 1; end
         2'd2:    begin tgt_l = base >> 1; tgt_r = base;      end
         default: begin tgt_l = base;      tgt_r = base;      end
      endcase
   end

   assign tick = (div_q == RW'(RAMP_DIV - 1));

   always_comb begin
      div_d    = tick ? '0 : div_q + RW'(1);
      cnt_d    = cnt_q + PWM_BITS'(1);
      duty_l_d = duty_l_q;
      duty_r_d = duty_r_q;
      app_l_d  = app_l_q;
      app_r_d  = app_r_q;
      pwm_l_d  = run_en && (cnt_q < app_l_q);
      pwm_r_d  = run_en && (cnt_q < app_r_q);
      if (!run_en) begin
         duty_l_d = '0;
         duty_r_d = '0;
         app_l_d  = '0;
         app_r_d  = '0;
      end else begin
         if (cnt_q == '1) begin
            app_l_d = duty_l_q;
            app_r_d = duty_r_q;
         end
         if (tick) begin
            duty_l_d = ramp_step(duty_l_q, tgt_l);
            duty_r_d = ramp_step(duty_r_q, tgt_r);
         end
      end
   end

   // Idle indicators keep phase preset so a fresh request lights immediately.
   always_comb begin
      blink_d = blink_q;
      phase_d = phase_q;
      if (!(RH || LH)) begin
         blink_d = '0;
         phase_d = 1'b1;
      end else if (blink_q == BW'(BLINK_DIV - 1)) begin
         blink_d = '0;
         phase_d = ~phase_q;
      end else begin
         blink_d = blink_q + BW'(1);
      end
      rh_d = RH & phase_q;
      lh_d = LH & phase_q;
      tl_d = TL;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         div_q    <= '0;
         cnt_q    <= '0;
         duty_l_q <= '0;
         duty_r_q <= '0;
         app_l_q  <= '0;
         app_r_q  <= '0;
         pwm_l_q  <= 1'b0;
         pwm_r_q  <= 1'b0;
         blink_q  <= '0;
         phase_q  <= 1'b1;
         rh_q     <= 1'b0;
         lh_q     <= 1'b0;
         tl_q     <= 1'b0;
      end else begin
         div_q    <= div_d;
         cnt_q    <= cnt_d;
         duty_l_q <= duty_l_d;
         duty_r_q <= duty_r_d;
         app_l_q  <= app_l_d;
         app_r_q  <= app_r_d;
         pwm_l_q  <= pwm_l_d;
         pwm_r_q  <= pwm_r_d;
         blink_q  <= blink_d;
         phase_q  <= phase_d;
         rh_q     <= rh_d;
         lh_q     <= lh_d;
         tl_q     <= tl_d;
      end
   end

   assign pwm_l   = pwm_l_q;
   assign pwm_r   = pwm_r_q;
   assign duty_l  = duty_l_q;
   assign duty_r  = duty_r_q;
   assign ramping = run_now && ((duty_l_q != tgt_l) || (duty_r_q != tgt_r));
   assign rh_lamp = rh_q;
   assign lh_lamp = lh_q;
   assign tl_lamp = tl_q;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Bench for motor_pwm_driver: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an arithmetic reference model.
module tb_motor_pwm_driver;

   localparam int PWM_BITS  = 8;
   localparam int RAMP_DIV  = 16;
   localparam int STEP      = 4;
   localparam int BLINK_DIV = 4;
   localparam int PERIOD    = 1 << PWM_BITS;

   logic                clk = 1'b0;
   logic                clr, E, RH, LH, TL;
   logic [2:0]          M1;
   logic [1:0]          M2;
   logic                pwm_l, pwm_r, ramping, rh_lamp, lh_lamp, tl_lamp;
   logic [PWM_BITS-1:0] duty_l, duty_r;

   int  n_checks = 0;
   int  n_errors = 0;
   bit  chk_en   = 1'b0;

   motor_pwm_driver #(
      .PWM_BITS(PWM_BITS), .RAMP_DIV(RAMP_DIV), .STEP(STEP), .BLINK_DIV(BLINK_DIV)
   ) dut (
      .clk(clk), .clr(clr), .E(E), .M1(M1), .M2(M2), .RH(RH), .LH(LH), .TL(TL),
      .pwm_l(pwm_l), .pwm_r(pwm_r), .duty_l(duty_l), .duty_r(duty_r),
      .ramping(ramping), .rh_lamp(rh_lamp), .lh_lamp(lh_lamp), .tl_lamp(tl_lamp)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic int base_of(input int m1);
      case (m1)
         1: return 64;
         2: return 128;
         3: return 192;
         default: return 0;
      endcase
   endfunction

   function automatic int tgt_l_of(input int m1, input int m2);
      return (m2 == 2) ? base_of(m1) / 2 : base_of(m1);
   endfunction

   function automatic int tgt_r_of(input int m1, input int m2);
      return (m2 == 1) ? base_of(m1) / 2 : base_of(m1);
   endfunction

   function automatic int approach(input int d, input int t);
      if ((t - d <= STEP) && (d - t <= STEP)) return t;
      return (t > d) ? d + STEP : d - STEP;
   endfunction

   function automatic bit blink_on(input int active);
      return ((active / BLINK_DIV) % 2) == 0;
   endfunction

   // Reference model: n counts clocks since reset, which fixes both the PWM counter
   // value and the ramp tick; 'active' counts clocks since an indicator request began.
   int m_n, m_dl, m_dr, m_al, m_ar, m_act;
   bit m_pl, m_pr, m_rh, m_lh, m_tl, m_run;

   always @(posedge clk) begin
      int cnt_old;
      bit tick;
      if (clr) begin
         m_n = 0; m_dl = 0; m_dr = 0; m_al = 0; m_ar = 0; m_act = 0;
         m_pl = 0; m_pr = 0; m_rh = 0; m_lh = 0; m_tl = 0; m_run = 0;
      end else begin
         cnt_old = m_n % PERIOD;
         tick    = (m_n % RAMP_DIV) == RAMP_DIV - 1;
         m_rh    = RH && blink_on(m_act);
         m_lh    = LH && blink_on(m_act);
         m_tl    = TL;
         m_act   = (RH || LH) ? m_act + 1 : 0;
         if (E) begin
            m_pl = cnt_old < m_al;
            m_pr = cnt_old < m_ar;
            if (cnt_old == PERIOD - 1) begin
               m_al = m_dl;
               m_ar = m_dr;
            end
            if (tick) begin
               m_dl = approach(m_dl, tgt_l_of(int'(M1), int'(M2)));
               m_dr = approach(m_dr, tgt_r_of(int'(M1), int'(M2)));
            end
         end else begin
            m_pl = 0; m_pr = 0; m_dl = 0; m_dr = 0; m_al = 0; m_ar = 0;
         end
         m_run = E;
         m_n++;
      end
   end

   always @(negedge clk) begin
      bit exp_ramp;
      if (chk_en) begin
         exp_ramp = m_run && ((m_dl != tgt_l_of(int'(M1), int'(M2))) ||
                              (m_dr != tgt_r_of(int'(M1), int'(M2))));
         check_eq("model duty_l",  int'(duty_l),  m_dl);
         check_eq("model duty_r",  int'(duty_r),  m_dr);
         check_eq("model pwm_l",   int'(pwm_l),   int'(m_pl));
         check_eq("model pwm_r",   int'(pwm_r),   int'(m_pr));
         check_eq("model ramping", int'(ramping), int'(exp_ramp));
         check_eq("model rh_lamp", int'(rh_lamp), int'(m_rh));
         check_eq("model lh_lamp", int'(lh_lamp), int'(m_lh));
         check_eq("model tl_lamp", int'(tl_lamp), int'(m_tl));
      end
   end

   // Waits (bounded) until ramping drops; returns clocks waited, or -1 on timeout.
   task automatic wait_idle(input int limit, output int waited);
      waited = -1;
      for (int i = 1; i <= limit; i++) begin
         @(posedge clk); #3;
         if (!ramping) begin
            waited = i;
            break;
         end
      end
      if (waited < 0) check_eq("wait_idle timeout", 1, 0);
   endtask

   initial begin
      int waited, hi_l, hi_r;
      bit found;
      clr = 1; E = 0; M1 = 0; M2 = 0; RH = 0; LH = 0; TL = 0;
      repeat (3) @(posedge clk);
      #1 chk_en = 1'b1;
      #2;
      check_eq("reset duty_l",  int'(duty_l),  0);
      check_eq("reset pwm_l",   int'(pwm_l),   0);
      check_eq("reset ramping", int'(ramping), 0);
      check_eq("reset rh_lamp", int'(rh_lamp), 0);

      // Slow speed ramp from 0 to 64
      E = 1; M1 = 1; M2 = 0;
      @(posedge clk); #2 clr = 0;
      repeat (255) @(posedge clk);
      #3;
      check_eq("ramp41 duty_l@255",  int'(duty_l),  60);
      check_eq("ramp41 duty_r@255",  int'(duty_r),  60);
      check_eq("ramp41 ramping@255", int'(ramping), 1);
      @(posedge clk); #3;
      check_eq("ramp41 duty_l@256",  int'(duty_l),  64);
      check_eq("ramp41 duty_r@256",  int'(duty_r),  64);
      check_eq("ramp41 ramping@256", int'(ramping), 0);

      // Steady duty 64: any 256-clock window has 64 high clocks
      repeat (400) @(posedge clk);
      hi_l = 0; hi_r = 0;
      for (int i = 0; i < PERIOD; i++) begin
         @(negedge clk);
         hi_l += int'(pwm_l);
         hi_r += int'(pwm_r);
      end
      check_eq("period highs pwm_l", hi_l, 64);
      check_eq("period highs pwm_r", hi_r, 64);

      // High speed, then right turn and back
      @(posedge clk); #2 M1 = 3;
      wait_idle(2000, waited);
      check_eq("high duty_l", int'(duty_l), 192);
      check_eq("high duty_r", int'(duty_r), 192);
      M2 = 1;
      wait_idle(2000, waited);
      check_eq("right duty_r", int'(duty_r), 96);
      check_eq("right duty_l", int'(duty_l), 192);
      check_eq("right 24 ticks", int'(waited > 23 * RAMP_DIV && waited <= 24 * RAMP_DIV), 1);
      M2 = 0;
      wait_idle(2000, waited);
      check_eq("straight duty_r", int'(duty_r), 192);

      // Duty 128, drop E while pwm is high
      M1 = 2;
      wait_idle(2000, waited);
      check_eq("med duty_l", int'(duty_l), 128);
      found = 0;
      for (int i = 0; i < 3 * PERIOD; i++) begin
         @(posedge clk); #2;
         if (pwm_l) begin
            found = 1;
            break;
         end
      end
      check_eq("pwm high before drop", int'(found), 1);
      E = 0;
      @(posedge clk); #3;
      check_eq("drop duty_l",  int'(duty_l),  0);
      check_eq("drop duty_r",  int'(duty_r),  0);
      check_eq("drop pwm_l",   int'(pwm_l),   0);
      check_eq("drop pwm_r",   int'(pwm_r),   0);
      check_eq("drop ramping", int'(ramping), 0);

      // Indicators
      RH = 1;
      for (int j = 1; j <= 12; j++) begin
         @(posedge clk); #3;
         check_eq("rh blink", int'(rh_lamp), int'(((j - 1) / BLINK_DIV) % 2 == 0));
      end
      LH = 1;
      for (int j = 1; j <= 12; j++) begin
         @(posedge clk); #3;
         check_eq("hazard in phase", int'(lh_lamp), int'(rh_lamp));
      end
      TL = 1;
      check_eq("tl before edge", int'(tl_lamp), 0);
      @(posedge clk); #3;
      check_eq("tl after edge", int'(tl_lamp), 1);
      RH = 0; LH = 0; TL = 0;

      // Reset mid-ramp at duty 40
      clr = 1;
      @(posedge clk); #3;
      clr = 0; E = 1; M1 = 2; M2 = 0;
      found = 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #3;
         if (duty_l == 40) begin
            found = 1;
            break;
         end
      end
      check_eq("reached duty 40", int'(found), 1);
      clr = 1;
      @(posedge clk); #3;
      check_eq("clr duty_l",  int'(duty_l),  0);
      check_eq("clr duty_r",  int'(duty_r),  0);
      check_eq("clr pwm_l",   int'(pwm_l),   0);
      check_eq("clr ramping", int'(ramping), 0);
      clr = 0;
      repeat (15) @(posedge clk);
      #3 check_eq("restart duty_l@15", int'(duty_l), 0);
      @(posedge clk); #3;
      check_eq("restart duty_l@16", int'(duty_l), 4);
      check_eq("restart duty_r@16", int'(duty_r), 4);

      // Randomized traffic against the model
      for (int c = 0; c < 6000; c++) begin
         @(posedge clk); #2;
         clr = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 499) == 0) E = ~E;
         if (!E && $urandom_range(0, 49) == 0) E = 1;
         if ($urandom_range(0, 149) == 0) M1 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 149) == 0) M2 = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 39) == 0) RH = ~RH;
         if ($urandom_range(0, 39) == 0) LH = ~LH;
         if ($urandom_range(0, 29) == 0) TL = ~TL;
      end
      clr = 0;
      repeat (4) @(posedge clk);
      #3;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
